// File: rtl/sum_pkg.sv
// sum_rr_sched shared types: FSM state enum, default widths,
// and the requester-id width helper used by every file.
package sum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_SUM_W  = 16;
    localparam int DEF_LEN_W  = 8;

    // Keep the id at least 1 bit wide so a 1-requester build still elaborates.
    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sum_rr_sched_if.sv
// Requester-side bundle of sum_rr_sched: job requests, sample stream,
// grant/ready back-pressure and the finished-job result.
// master = requesters/producers, slave = the scheduler.
interface sum_rr_sched_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 8,
    parameter int SUM_W   = 16,
    parameter int LEN_W   = 8
);
    import sum_pkg::*;

    localparam int IDW = id_w(NUM_REQ);

    logic [NUM_REQ-1:0]        i_req;
    logic [NUM_REQ*LEN_W-1:0]  i_len;
    logic [NUM_REQ-1:0]        i_valid;
    logic [NUM_REQ*DATA_W-1:0] i_data;
    logic [NUM_REQ-1:0]        o_ready;
    logic [NUM_REQ-1:0]        o_gnt;
    logic                      o_busy;
    logic                      o_done;
    logic [IDW-1:0]            o_done_id;
    logic [SUM_W-1:0]          o_sum;
    logic                      o_overflow;

    modport master (
        output i_req, i_len, i_valid, i_data,
        input  o_ready, o_gnt, o_busy, o_done,
        input  o_done_id, o_sum, o_overflow
    );

    modport slave (
        input  i_req, i_len, i_valid, i_data,
        output o_ready, o_gnt, o_busy, o_done,
        output o_done_id, o_sum, o_overflow
    );

endinterface

// File: rtl/sum_rr_arb.sv
// Combinational round-robin pick: first set req bit at or above ptr,
// wrapping upward. Ports: req, ptr in; one-hot gnt, binary id, any out.
module sum_rr_arb
    import sum_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDW     = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     id,
    output logic               any
);

    logic [IDW-1:0] k;

    always_comb begin
        gnt = '0;
        id  = '0;
        any = 1'b0;
        k   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = IDW'((int'(ptr) + i) % NUM_REQ);
            if (!any && req[k]) begin
                any    = 1'b1;
                id     = k;
                gnt[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sum_rr_sched.sv
// Round-robin scheduler sharing one accumulator among NUM_REQ requesters.
// Ports: CLK, RST_n (async, active-low), bus (sum_rr_sched_if.slave).
// Define SUM_SAT_EN to saturate the accumulator instead of wrapping.
module sum_rr_sched
    import sum_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SUM_W   = DEF_SUM_W,
    parameter int LEN_W   = DEF_LEN_W
) (
    input logic          CLK,
    input logic          RST_n,
    sum_rr_sched_if.slave bus
);

    localparam int IDW = id_w(NUM_REQ);

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [SUM_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic               sovf_q, sovf_d;
    logic [IDW-1:0]     did_q, did_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDW-1:0]     arb_id;
    logic               arb_any;

    sum_rr_arb #(
        .NUM_REQ(NUM_REQ),
        .IDW    (IDW)
    ) u_arb (
        .req(bus.i_req),
        .ptr(ptr_q),
        .gnt(arb_gnt),
        .id (arb_id),
        .any(arb_any)
    );

    logic [LEN_W-1:0]  k_len;
    logic [DATA_W-1:0] k_data;
    logic              live;
    logic [SUM_W:0]    ext;
    logic [SUM_W-1:0]  acc_add;
    logic [LEN_W-1:0]  cnt_inc;
    logic [IDW-1:0]    ptr_inc;

    assign k_len  = bus.i_len[int'(arb_id)*LEN_W +: LEN_W];
    assign k_data = bus.i_data[int'(id_q)*DATA_W +: DATA_W];
    // Ready is withdrawn as soon as the owner drops its request.
    assign live   = (state_q == ST_RUN) && bus.i_req[id_q];
    assign ext    = {1'b0, acc_q}
                  + {{(SUM_W+1-DATA_W){1'b0}}, k_data};

`ifdef SUM_SAT_EN
    assign acc_add = ext[SUM_W] ? '1 : ext[SUM_W-1:0];
`else
    assign acc_add = ext[SUM_W-1:0];
`endif

    assign cnt_inc = cnt_q + 1'b1;
    assign ptr_inc = (id_q == IDW'(NUM_REQ-1)) ? '0 : id_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        sum_d   = sum_q;
        sovf_d  = sovf_q;
        did_d   = did_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    gnt_d = arb_gnt;
                    id_d  = arb_id;
                    len_d = k_len;
                    cnt_d = '0;
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (k_len == '0) begin
                        state_d = ST_DONE;
                        sum_d   = '0;
                        sovf_d  = 1'b0;
                        did_d   = arb_id;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (!bus.i_req[id_q]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    ptr_d   = ptr_inc;
                end else if (bus.i_valid[id_q]) begin
                    acc_d = acc_add;
                    ovf_d = ovf_q | ext[SUM_W];
                    cnt_d = cnt_inc;
                    // Result is published on entry so it lines up with o_done.
                    if (cnt_inc == len_q) begin
                        state_d = ST_DONE;
                        sum_d   = acc_add;
                        sovf_d  = ovf_q | ext[SUM_W];
                        did_d   = id_q;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                ptr_d   = ptr_inc;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            id_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            sum_q   <= '0;
            sovf_q  <= 1'b0;
            did_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            sum_q   <= sum_d;
            sovf_q  <= sovf_d;
            did_q   <= did_d;
        end
    end

    assign bus.o_ready    = live ? gnt_q : '0;
    assign bus.o_gnt      = gnt_q;
    assign bus.o_busy     = (state_q != ST_IDLE);
    assign bus.o_done     = (state_q == ST_DONE);
    assign bus.o_done_id  = did_q;
    assign bus.o_sum      = sum_q;
    assign bus.o_overflow = sovf_q;

endmodule

// File: tb/tb_sum_rr_sched.sv
// Directed bench for sum_rr_sched: job table, RR alternation, abort,
// async reset, and an 8-bit accumulator instance for carry-out.
module tb_sum_rr_sched;
    import sum_pkg::*;

    logic CLK = 1'b0;
    logic RST_n = 1'b0;
    always #5 CLK = ~CLK;

    sum_rr_sched_if bus ();
    sum_rr_sched_if #(.SUM_W(8)) bus8 ();

    sum_rr_sched dut (
        .CLK  (CLK),
        .RST_n(RST_n),
        .bus  (bus.slave)
    );

    sum_rr_sched #(.SUM_W(8)) dut8 (
        .CLK  (CLK),
        .RST_n(RST_n),
        .bus  (bus8.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int id;
        int len;
        int d0;
        int step;
        bit gaps;
        int exp_sum;
        bit exp_ovf;
    } job_t;

    job_t jobs[6];

    task automatic run_job(input int n, input job_t j);
        string t;
        int cyc;
        int acc_n;
        bit prev_acc;
        bit got;
        bit tgl;
        bit v;
        bit rbad;
        bit done_ok;
        t = $sformatf("job%0d", n);
        bus.i_req[j.id] = 1'b1;
        bus.i_len[j.id*8 +: 8] = j.len[7:0];
        @(posedge CLK); #1;
        chk({t, "_gnt"}, 32'(bus.o_gnt), 32'(1 << j.id));
        chk({t, "_busy"}, 32'(bus.o_busy), 32'd1);
        // Must not disturb the latched length.
        bus.i_len[j.id*8 +: 8] = ~j.len[7:0];
        acc_n = 0;
        prev_acc = 1'b0;
        got = 1'b0;
        tgl = 1'b1;
        rbad = 1'b0;
        for (cyc = 0; cyc < 600; cyc++) begin
            if (bus.o_done) begin
                got = 1'b1;
                break;
            end
            v = j.gaps ? tgl : 1'b1;
            tgl = ~tgl;
            bus.i_valid[j.id] = v;
            bus.i_data[j.id*8 +: 8] = 8'(j.d0 + acc_n * j.step);
            if (bus.o_ready[1-j.id]) rbad = 1'b1;
            prev_acc = v && bus.o_ready[j.id];
            @(posedge CLK); #1;
            if (prev_acc) acc_n++;
        end
        done_ok = (j.len == 0) ? (cyc == 0) : prev_acc;
        chk({t, "_done_seen"}, 32'(got), 32'd1);
        chk({t, "_done_lat"}, 32'(done_ok), 32'd1);
        chk({t, "_sum"}, 32'(bus.o_sum), 32'(j.exp_sum));
        chk({t, "_ovf"}, 32'(bus.o_overflow), 32'(j.exp_ovf));
        chk({t, "_id"}, 32'(bus.o_done_id), 32'(j.id));
        chk({t, "_accepts"}, 32'(acc_n), 32'(j.len));
        chk({t, "_other_rdy"}, 32'(rbad), 32'd0);
        bus.i_req[j.id] = 1'b0;
        bus.i_valid[j.id] = 1'b0;
        @(posedge CLK); #1;
        chk({t, "_idle"},
            32'({bus.o_done, bus.o_busy, bus.o_gnt}), 32'd0);
        chk({t, "_hold"}, 32'(bus.o_sum), 32'(j.exp_sum));
    endtask

    initial begin
        int seq[$];
        int exp_alt[4];
        bit multi;
        bit rdy_bad;

        bus.i_req = '0;
        bus.i_len = '0;
        bus.i_valid = '0;
        bus.i_data = '0;
        bus8.i_req = '0;
        bus8.i_len = '0;
        bus8.i_valid = '0;
        bus8.i_data = '0;

        jobs[0] = '{0,   4,  10, 10, 1'b0,   100, 1'b0};
        jobs[1] = '{1, 255, 255,  0, 1'b0, 65025, 1'b0};
        jobs[2] = '{0,   0,   9,  0, 1'b0,     0, 1'b0};
        jobs[3] = '{1,   3,   5,  1, 1'b1,    18, 1'b0};
        jobs[4] = '{0,   1, 200,  0, 1'b0,   200, 1'b0};
        jobs[5] = '{1,   2, 100, 50, 1'b0,   250, 1'b0};
        exp_alt = '{0, 1, 0, 1};

        #2;
        chk("rst_outs", 32'({bus.o_ready, bus.o_gnt, bus.o_busy,
            bus.o_done, bus.o_done_id, bus.o_overflow}), 32'd0);
        chk("rst_sum", 32'(bus.o_sum), 32'd0);
        @(posedge CLK); #1;
        RST_n = 1'b1;
        @(posedge CLK); #1;
        chk("idle_gnt", 32'(bus.o_gnt), 32'd0);

        for (int n = 0; n < 6; n++) run_job(n, jobs[n]);

        // Both requesters compete continuously.
        multi = 1'b0;
        rdy_bad = 1'b0;
        bus.i_len = {8'd2, 8'd2};
        bus.i_data = {8'd1, 8'd1};
        bus.i_valid = 2'b11;
        bus.i_req = 2'b11;
        for (int c = 0; c < 100 && seq.size() < 4; c++) begin
            @(posedge CLK); #1;
            if ($countones(bus.o_gnt) > 1) multi = 1'b1;
            if ((bus.o_ready & ~bus.o_gnt) != 0) rdy_bad = 1'b1;
            if (bus.o_done) begin
                seq.push_back(int'(bus.o_done_id));
                chk("alt_sum", 32'(bus.o_sum), 32'd2);
            end
        end
        bus.i_req = '0;
        bus.i_valid = '0;
        chk("alt_count", 32'(seq.size()), 32'd4);
        for (int i = 0; i < seq.size(); i++)
            chk($sformatf("alt_id%0d", i), 32'(seq[i]), 32'(exp_alt[i]));
        chk("alt_onehot", 32'(multi), 32'd0);
        chk("alt_ready", 32'(rdy_bad), 32'd0);
        @(posedge CLK); #1;

        // Abort requester 0 after two of five samples.
        bus.i_len = {8'd1, 8'd5};
        bus.i_data = {8'd9, 8'd7};
        bus.i_valid = 2'b10;
        bus.i_req = 2'b11;
        @(posedge CLK); #1;
        chk("ab_gnt0", 32'(bus.o_gnt), 32'd1);
        chk("ab_rdy", 32'(bus.o_ready), 32'd1);
        bus.i_valid[0] = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("ab_still_run", 32'(bus.o_busy), 32'd1);
        bus.i_req[0] = 1'b0;
        bus.i_valid[0] = 1'b0;
        @(posedge CLK); #1;
        chk("ab_nodone", 32'({bus.o_done, bus.o_busy, bus.o_gnt}), 32'd0);
        chk("ab_sum_held", 32'(bus.o_sum), 32'd2);
        @(posedge CLK); #1;
        chk("ab_gnt1", 32'(bus.o_gnt), 32'd2);
        @(posedge CLK); #1;
        chk("ab_done1", 32'(bus.o_done), 32'd1);
        chk("ab_id1", 32'(bus.o_done_id), 32'd1);
        chk("ab_sum1", 32'(bus.o_sum), 32'd9);
        bus.i_req = '0;
        bus.i_valid = '0;
        @(posedge CLK); #1;

        // Asynchronous reset in the middle of a job.
        bus.i_len[7:0] = 8'd10;
        bus.i_data[7:0] = 8'd3;
        bus.i_valid[0] = 1'b1;
        bus.i_req[0] = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("mr_busy", 32'(bus.o_busy), 32'd1);
        #2 RST_n = 1'b0;
        #1;
        chk("mr_outs", 32'({bus.o_ready, bus.o_gnt, bus.o_busy,
            bus.o_done, bus.o_done_id, bus.o_overflow}), 32'd0);
        chk("mr_sum", 32'(bus.o_sum), 32'd0);
        bus.i_req = '0;
        bus.i_valid = '0;
        @(posedge CLK); #1;
        RST_n = 1'b1;
        @(posedge CLK); #1;

        // 8-bit accumulator: 200 + 100 carries out.
        bus8.i_len[7:0] = 8'd2;
        bus8.i_data[7:0] = 8'd200;
        bus8.i_valid[0] = 1'b1;
        bus8.i_req[0] = 1'b1;
        @(posedge CLK); #1;
        chk("w8_gnt", 32'(bus8.o_gnt), 32'd1);
        @(posedge CLK); #1;
        bus8.i_data[7:0] = 8'd100;
        @(posedge CLK); #1;
        chk("w8_done", 32'(bus8.o_done), 32'd1);
`ifdef SUM_SAT_EN
        chk("w8_sum", 32'(bus8.o_sum), 32'd255);
`else
        chk("w8_sum", 32'(bus8.o_sum), 32'd44);
`endif
        chk("w8_ovf", 32'(bus8.o_overflow), 32'd1);
        bus8.i_req = '0;
        bus8.i_valid = '0;
        @(posedge CLK); #1;
        chk("w8_hold", 32'({bus8.o_overflow, bus8.o_done}), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
